qm_mq: RTL



---
 rtl/qm_mq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/qm_mq.sv
// Multi-queue output-port queue manager: filters the switch byte stream by port mask,
// admits whole frames into per-class data/pointer FIFOs and serves per-queue reads.
module qm_mq #(
    parameter int NUM_Q     = 4,
    parameter int DADDR_W   = 12,
    parameter int PADDR_W   = 5,
    parameter int BP_THRESH = 2578
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [3:0]               port_id,
    input  logic                     sof,
    input  logic                     dv,
    input  logic [7:0]               data,
    input  logic [$clog2(NUM_Q)-1:0] prio,
    output logic [NUM_Q-1:0]         bp,
    output logic [15:0]              drop_cnt,
    input  logic [$clog2(NUM_Q)-1:0] rd_q,
    input  logic                     data_fifo_rd,
    output logic [7:0]               data_fifo_dout,
    input  logic                     ptr_fifo_rd,
    output logic [15:0]              ptr_fifo_dout,
    output logic [NUM_Q-1:0]         ptr_fifo_empty
);
    localparam int Q_W    = $clog2(NUM_Q);
    localparam int DDEPTH = 2 ** DADDR_W;
    localparam int PDEPTH = 2 ** PADDR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR2    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [3:0]         len_hi_q, len_hi_d;
    logic [11:0]        plen_q, plen_d;
    logic [11:0]        cnt_q, cnt_d;
    logic [Q_W-1:0]     q_q, q_d;
    logic               wr_en_q, wr_en_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               push_ptr, drop_inc;
    logic [15:0]        drop_cnt_q;
    logic [7:0]         data_dout_q;
    logic [15:0]        ptr_dout_q;

    logic [DADDR_W:0]   dcnt_q [NUM_Q];
    logic [DADDR_W-1:0] dwp_q  [NUM_Q];
    logic [DADDR_W-1:0] drp_q  [NUM_Q];
    logic [PADDR_W:0]   pcnt_q [NUM_Q];
    logic [PADDR_W-1:0] pwp_q  [NUM_Q];
    logic [PADDR_W-1:0] prp_q  [NUM_Q];
    logic [7:0]         dmem   [NUM_Q*DDEPTH];
    logic [15:0]        pmem   [NUM_Q*PDEPTH];

    logic [11:0]        len_full;
    logic [DADDR_W:0]   free_space;
    logic               d_pop, p_pop;
    logic [15:0]        ptr_word;
    logic [NUM_Q-1:0]   p_full, d_wr_vec, d_rd_vec, p_wr_vec, p_rd_vec;

    assign len_full       = {len_hi_q, data};
    assign free_space     = (DADDR_W+1)'(DDEPTH) - dcnt_q[q_q];
    assign d_pop          = data_fifo_rd && (dcnt_q[rd_q] != '0);
    assign p_pop          = ptr_fifo_rd && (pcnt_q[rd_q] != '0);
    assign ptr_word       = {(cnt_q < plen_q), 3'b000, cnt_q};
    assign drop_cnt       = drop_cnt_q;
    assign data_fifo_dout = data_dout_q;
    assign ptr_fifo_dout  = ptr_dout_q;

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            p_full[i]         = (pcnt_q[i] == (PADDR_W+1)'(PDEPTH));
            bp[i]             = (32'(dcnt_q[i]) > BP_THRESH) | p_full[i];
            ptr_fifo_empty[i] = (pcnt_q[i] == '0);
            d_wr_vec[i]       = wr_en_q && (q_q == Q_W'(i));
            d_rd_vec[i]       = d_pop && (rd_q == Q_W'(i));
            p_wr_vec[i]       = push_ptr && (q_q == Q_W'(i));
            p_rd_vec[i]       = p_pop && (rd_q == Q_W'(i));
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        plen_d    = plen_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        push_ptr  = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sof && ((port_id & data[3:0]) != 4'd0)) begin
                    len_hi_d = data[7:4];
                    q_d      = prio;
                    state_d  = S_HDR2;
                end
            end
            S_HDR2: begin
                plen_d = len_full - 12'd2;
                cnt_d  = '0;
                // Exact check: the previous frame's writes have all landed by now.
                if (len_full < 12'd3 || p_full[q_q] ||
                    (32'(free_space) < 32'(len_full) - 32'd2)) begin
                    drop_inc = 1'b1;
                    state_d  = S_DISCARD;
                end else begin
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!dv) begin
                    state_d = S_COMMIT;
                end else if (cnt_q < plen_q) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = data;
                    cnt_d     = cnt_q + 12'd1;
                end
            end
            S_DISCARD: begin
                if (!dv) state_d = S_IDLE;
            end
            S_COMMIT: begin
                if (cnt_q == '0) drop_inc = 1'b1;
                else             push_ptr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            plen_q     <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            plen_q    <= plen_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_Q; i++) begin
                dcnt_q[i] <= '0;
                dwp_q[i]  <= '0;
                drp_q[i]  <= '0;
                pcnt_q[i] <= '0;
                pwp_q[i]  <= '0;
                prp_q[i]  <= '0;
            end
            data_dout_q <= '0;
            ptr_dout_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (d_wr_vec[i]) dwp_q[i] <= dwp_q[i] + DADDR_W'(1);
                if (d_rd_vec[i]) drp_q[i] <= drp_q[i] + DADDR_W'(1);
                if (d_wr_vec[i] && !d_rd_vec[i])      dcnt_q[i] <= dcnt_q[i] + (DADDR_W+1)'(1);
                else if (!d_wr_vec[i] && d_rd_vec[i]) dcnt_q[i] <= dcnt_q[i] - (DADDR_W+1)'(1);
                if (p_wr_vec[i]) pwp_q[i] <= pwp_q[i] + PADDR_W'(1);
                if (p_rd_vec[i]) prp_q[i] <= prp_q[i] + PADDR_W'(1);
                if (p_wr_vec[i] && !p_rd_vec[i])      pcnt_q[i] <= pcnt_q[i] + (PADDR_W+1)'(1);
                else if (!p_wr_vec[i] && p_rd_vec[i]) pcnt_q[i] <= pcnt_q[i] - (PADDR_W+1)'(1);
            end
            if (d_pop) data_dout_q <= dmem[{rd_q, drp_q[rd_q]}];
            if (p_pop) ptr_dout_q  <= pmem[{rd_q, prp_q[rd_q]}];
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_q)  dmem[{q_q, dwp_q[q_q]}] <= wr_data_q;
        if (push_ptr) pmem[{q_q, pwp_q[q_q]}] <= ptr_word;
    end

endmodule
